updown_sweep_ctrl: RTL and testbench

- Upstream command sequencer for the 8-bit up/down counter (ports mode, clr, ld, d_in, count).
- Accepts sweep commands on a valid/ready handshake and drives the counter's control pins to produce the requested sequence.
- The counter has no enable, so every hold is implemented as a load of the current count.
- Watches the counter's count feedback to detect the limit and turn points.

---
 rtl/updown_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// ============================================================================
//  Module      : updown_sweep_ctrl
//  Description : Command sequencer for an 8-bit up/down counter. It accepts
//                sweep commands on a valid/ready handshake. It drives the
//                counter pins (mode, clr, ld, d_in) so the counter runs from
//                start to limit. The counter can bounce between the two
//                points a set number of times.
//                Optional macro UPDOWN_SWEEP_TURNCNT_EN adds a saturating
//                16-bit turnaround counter output (turn_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAPW  = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_start,
    input  logic [WIDTH-1:0]  cmd_limit,
    input  logic              cmd_dir,
    input  logic [LAPW-1:0]   cmd_laps,
    input  logic              abort,
    input  logic [WIDTH-1:0]  count,
    output logic              mode,
    output logic              clr,
    output logic              ld,
    output logic [WIDTH-1:0]  d_in,
    output logic              busy,
    output logic              done,
`ifdef UPDOWN_SWEEP_TURNCNT_EN
    output logic [15:0]       turn_cnt,
`endif
    output logic              aborted
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_dir;        // current counting direction (1 = up)
    logic               r_ret;        // 1 while on the return leg toward start
    logic [WIDTH-1:0]   r_start_q;
    logic [WIDTH-1:0]   r_limit_q;
    logic [LAPW-1:0]    r_laps_left;
    logic               r_done;
    logic               r_aborted;

    logic               w_accept;
    logic               w_degenerate;
    logic [WIDTH-1:0]   w_target;
    logic               w_hit;
    logic               w_run_ok;
    logic               w_turn;
    logic               w_finish;

    // The outbound leg ends at the limit and the return leg ends at start.
    // When start equals limit, the first RUN cycle ends the command and the
    // lap budget is not used.
    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_degenerate = (r_start_q == r_limit_q);
    assign w_target     = r_ret ? r_start_q : r_limit_q;
    assign w_hit        = (count == w_target);
    assign w_run_ok     = (r_state == S_RUN) && !abort;
    assign w_turn       = w_run_ok && w_hit && !w_degenerate && (r_laps_left != '0);
    assign w_finish     = w_run_ok && w_hit && (w_degenerate || (r_laps_left == '0));

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done      = r_done;
    assign aborted   = r_aborted;

    // Decode the counter pins without a register so the counter acts on the
    // same edge where the FSM advances. The counter has no enable, so each
    // hold is done as a reload of the current count.
    always_comb begin
        clr  = 1'b0;
        ld   = 1'b0;
        mode = r_dir;
        d_in = count;
        case (r_state)
            S_INIT: begin
                clr = 1'b1;
            end
            S_IDLE: begin
                ld = 1'b1;
            end
            S_LOAD: begin
                ld   = 1'b1;
                d_in = abort ? count : r_start_q;
            end
            S_RUN: begin
                if (abort || w_finish) begin
                    ld = 1'b1;
                end else if (w_turn) begin
                    mode = ~r_dir;
                end
            end
            S_FIN: begin
                ld = 1'b1;
            end
            default: begin
                clr = 1'b1;
            end
        endcase
    end

    // Sequencer FSM: latches the command, walks it through LOAD/RUN/FIN, and
    // pulses done or aborted for one cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_INIT;
            r_dir       <= 1'b1;
            r_ret       <= 1'b0;
            r_start_q   <= '0;
            r_limit_q   <= '0;
            r_laps_left <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_start_q   <= cmd_start;
                        r_limit_q   <= cmd_limit;
                        r_dir       <= cmd_dir;
                        r_laps_left <= cmd_laps;
                        r_ret       <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_finish) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (w_turn) begin
                        r_dir       <= ~r_dir;
                        r_ret       <= ~r_ret;
                        r_laps_left <= r_laps_left - 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

`ifdef UPDOWN_SWEEP_TURNCNT_EN
    logic [15:0] r_turn_cnt;

    assign turn_cnt = r_turn_cnt;

    // Count the turnarounds of the current command. The count clears when a
    // new command is accepted and stops at all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_turn_cnt <= '0;
        end else if (w_accept) begin
            r_turn_cnt <= '0;
        end else if (w_turn && (r_turn_cnt != 16'hFFFF)) begin
            r_turn_cnt <= r_turn_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
// ============================================================================
//  Module      : tb_updown_sweep_ctrl
//  Description : Directed self-checking bench for updown_sweep_ctrl, with a
//                behavioural model of the 8-bit up/down counter in the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_sweep_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_start = '0;
    logic [7:0]  cmd_limit = '0;
    logic        cmd_dir = 1'b1;
    logic [3:0]  cmd_laps = '0;
    logic        abort = 1'b0;
    logic [7:0]  count;
    logic        mode;
    logic        clr;
    logic        ld;
    logic [7:0]  d_in;
    logic        busy;
    logic        done;
    logic        aborted;
`ifdef UPDOWN_SWEEP_TURNCNT_EN
    logic [15:0] turn_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int seq [0:63];
    int seq_n;
    int expq [$];
    bit got_done;
    int ready_in_busy;

    updown_sweep_ctrl #(.WIDTH(8), .LAPW(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_limit (cmd_limit),
        .cmd_dir   (cmd_dir),
        .cmd_laps  (cmd_laps),
        .abort     (abort),
        .count     (count),
        .mode      (mode),
        .clr       (clr),
        .ld        (ld),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
`ifdef UPDOWN_SWEEP_TURNCNT_EN
        .turn_cnt  (turn_cnt),
`endif
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    // Behavioural counter: clr beats ld, and ld beats stepping.
    logic [7:0] r_cnt = 8'hA5;
    always @(posedge clk) begin
        if (clr)       r_cnt <= 8'd0;
        else if (ld)   r_cnt <= d_in;
        else if (mode) r_cnt <= r_cnt + 8'd1;
        else           r_cnt <= r_cnt - 8'd1;
    end
    assign count = r_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Issue one command, then record the count on every RUN cycle until
    // done shows up. The first busy cycle is LOAD, where count is still old.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] l, input logic d,
                           input logic [3:0] laps, input bit keep_valid);
        int k;
        cmd_start = s; cmd_limit = l; cmd_dir = d; cmd_laps = laps;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", cmd_ready, 1);
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
        check("load_busy", busy, 1);
        seq_n = 0; got_done = 0; ready_in_busy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (cmd_ready) ready_in_busy++;
            if (seq_n < 64) seq[seq_n] = count;
            seq_n++;
        end
        cmd_valid = 1'b0;
        check("done_seen", got_done, 1);
    endtask

    // Compare the recorded sequence with expq. Then check the FIN cycle, the
    // one-shot done pulse, and the hold afterwards.
    task automatic check_seq(input string tag);
        int last;
        check({tag, "_len"}, seq_n, expq.size());
        for (int i = 0; i < expq.size() && i < seq_n && i < 64; i++)
            check({tag, "_cnt"}, seq[i], expq[i]);
        last = expq[expq.size()-1];
        check({tag, "_fin_busy"}, busy, 0);
        check({tag, "_fin_hold"}, count, last);
        @(negedge clk);
        check({tag, "_done_once"}, done, 0);
        check({tag, "_ready_back"}, cmd_ready, 1);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, count, last);
    endtask

    initial begin
        int k;
        int n_done;
        int n_ab;

        // Reset: clr asserted the whole time, the counter cleared.
        repeat (3) @(negedge clk);
        check("rst_clr", clr, 1);
        check("rst_ld", ld, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_count", count, 0);
        clr_n = 1'b1;
        #1;
        check("init_clr_after_release", clr, 1);
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_clr", clr, 0);
        check("idle_ld", ld, 1);
        check("idle_count", count, 0);

        // Single up sweep.
        run_cmd(8'd10, 8'd15, 1'b1, 4'd0, 1'b0);
        expq = '{10, 11, 12, 13, 14, 15};
        check_seq("up");

        // Bounce with two turnarounds.
        run_cmd(8'd3, 8'd6, 1'b1, 4'd2, 1'b0);
        expq = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6};
        check_seq("bounce");
`ifdef UPDOWN_SWEEP_TURNCNT_EN
        check("bounce_turn_cnt", turn_cnt, 2);
`endif

        // Wrap-around both directions.
        run_cmd(8'd254, 8'd1, 1'b1, 4'd0, 1'b0);
        expq = '{254, 255, 0, 1};
        check_seq("wrap_up");
        run_cmd(8'd1, 8'd254, 1'b0, 4'd0, 1'b0);
        expq = '{1, 0, 255, 254};
        check_seq("wrap_dn");

        // Abort at 120.
        cmd_start = 8'd100; cmd_limit = 8'd200; cmd_dir = 1'b1; cmd_laps = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (count != 8'd120 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_120", count, 120);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_hold", count, 120);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        n_done = 0; n_ab = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_done += int'(done);
            n_ab   += int'(aborted);
        end
        check("abort_no_done", n_done, 0);
        check("abort_pulse_once", n_ab, 0);
        check("abort_hold_later", count, 120);

        // start == limit: finishes at once, and the laps are ignored.
        run_cmd(8'd50, 8'd50, 1'b1, 4'd3, 1'b0);
        expq = '{50};
        check_seq("degen");
`ifdef UPDOWN_SWEEP_TURNCNT_EN
        check("degen_turn_cnt", turn_cnt, 0);
`endif

        // cmd_valid held high for the whole command: no accept while busy.
        run_cmd(8'd20, 8'd25, 1'b1, 4'd0, 1'b1);
        check("hold_valid_no_ready", ready_in_busy, 0);
        expq = '{20, 21, 22, 23, 24, 25};
        check_seq("hold_valid");

        // Reset in the middle of RUN.
        cmd_start = 8'd0; cmd_limit = 8'd100; cmd_dir = 1'b1; cmd_laps = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        clr_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_clr", clr, 1);
        check("midrst_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        check("midrst_count", count, 0);
        clr_n = 1'b1;
        n_done = 0; n_ab = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_done += int'(done);
            n_ab   += int'(aborted);
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_no_abort", n_ab, 0);
        check("midrst_ready_back", cmd_ready, 1);
        check("midrst_count_after", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
